// File: rtl/speed_cmd_sequencer_pkg.sv
// Shared constants, types and the step-protocol rule for the speed command sequencer.
package speed_cmd_sequencer_pkg;

  localparam int SPEED_W     = 5;
  localparam int MAX_SPEED   = 4;
  localparam int FIFO_DEPTH  = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam int RAMP_CNT_W  = $clog2(TIMEOUT_CYC);

  typedef logic [SPEED_W-1:0] speed_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RAMP,
    DONE,
    FAULT
  } seq_state_t;

  // One extra bit so that stepping below 0 or above the top code never aliases a legal speed.
  function automatic logic step_violation(speed_t prev, speed_t cur,
                                          logic [1:0] up, logic [1:0] down);
    logic [SPEED_W:0] expected;
    expected = {1'b0, prev} + {{SPEED_W{1'b0}}, up[0]} - {{SPEED_W{1'b0}}, down[0]};
    return (expected != {1'b0, cur}) || (up[0] && down[0]) || up[1] || down[1];
  endfunction

endpackage

// File: rtl/speed_cmd_sequencer_if.sv
// Command-side handshake plus the request/feedback link to the ramping speed controller.
interface speed_cmd_sequencer_if;
  import speed_cmd_sequencer_pkg::*;

  logic       cmd_valid;
  speed_t     cmd_speed;
  logic       cmd_ready;
  speed_t     req_speed;
  logic [1:0] up_in;
  logic [1:0] down_in;
  speed_t     fspeed_in;

  modport master (
    input  cmd_valid, cmd_speed, up_in, down_in, fspeed_in,
    output cmd_ready, req_speed
  );

  modport slave (
    output cmd_valid, cmd_speed, up_in, down_in, fspeed_in,
    input  cmd_ready, req_speed
  );

endinterface

// File: rtl/speed_cmd_sequencer_fifo.sv
// Synchronous FIFO holding pending target speeds; pointers carry a wrap bit for full/empty.
module speed_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/speed_cmd_sequencer.sv
// Queues target speeds, issues them one at a time to the ramp controller and watches every step.
module speed_cmd_sequencer
  import speed_cmd_sequencer_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  speed_cmd_sequencer_if.master        bus,
  input  logic                         err_clr,
  output logic                         busy,
  output logic                         done,
  output logic                         err_range,
  output logic                         err_timeout,
  output logic                         err_step
);

  seq_state_t            state, state_nxt;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  speed_t                fifo_dout;
  speed_t                target;
  speed_t                req_speed_q;
  speed_t                prev_speed;
  logic [RAMP_CNT_W-1:0] ramp_cnt;
  logic                  cmd_accept, cmd_in_range;
  logic                  settled, ramp_expired;
  logic                  load_req, cnt_inc, timeout_set;
  logic                  step_bad;

  // Out-of-range commands are still handshaken so the source never stalls on them.
  assign bus.cmd_ready = !fifo_full;
  assign cmd_accept    = bus.cmd_valid && !fifo_full;
  assign cmd_in_range  = (bus.cmd_speed <= SPEED_W'(MAX_SPEED));
  assign fifo_push     = cmd_accept && cmd_in_range;
  assign bus.req_speed = req_speed_q;

  assign settled      = (bus.fspeed_in == req_speed_q) && (bus.up_in == 2'b00) && (bus.down_in == 2'b00);
  assign ramp_expired = (ramp_cnt == RAMP_CNT_W'(TIMEOUT_CYC - 1));
  assign step_bad     = step_violation(prev_speed, bus.fspeed_in, bus.up_in, bus.down_in);

  speed_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SPEED_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.cmd_speed),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, otherwise unlisted paths infer latches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!fifo_empty) state_nxt = ISSUE;
      ISSUE:   state_nxt = RAMP;
      RAMP: begin
        if (settled)           state_nxt = DONE;
        else if (ramp_expired) state_nxt = FAULT;
      end
      DONE:    state_nxt = IDLE;
      FAULT:   if (err_clr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fifo_pop    = 1'b0;
    load_req    = 1'b0;
    cnt_inc     = 1'b0;
    timeout_set = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE:  fifo_pop = !fifo_empty;
      ISSUE: load_req = 1'b1;
      RAMP: begin
        cnt_inc     = 1'b1;
        timeout_set = !settled && ramp_expired;
      end
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      target      <= '0;
      req_speed_q <= '0;
      ramp_cnt    <= '0;
      prev_speed  <= '0;
      err_range   <= 1'b0;
      err_timeout <= 1'b0;
      err_step    <= 1'b0;
    end else begin
      if (fifo_pop) target <= fifo_dout;

      if (load_req) begin
        req_speed_q <= target;
        ramp_cnt    <= '0;
      end else if (cnt_inc) begin
        ramp_cnt    <= ramp_cnt + 1'b1;
      end

      prev_speed <= bus.fspeed_in;
      err_range  <= cmd_accept && !cmd_in_range;

      // A new violation in the same cycle as err_clr keeps the flag set.
      err_timeout <= timeout_set || (err_timeout && !err_clr);
      err_step    <= step_bad    || (err_step    && !err_clr);
    end
  end

endmodule
